and_result_buffer: RTL

Downstream stage of the 4-bit AND gate block. It captures each `y1`/`y2` result pair offered by the producer and holds it in a small FIFO. It presents the oldest entry to the consumer under a valid/ready handshake, with the entry's bit population count. It also keeps a saturating count of accepted results whose `y2` (all-ones of operand `a`) was set.

---
 rtl/gates_pkg.sv | 17 +
 rtl/ones_count.sv | 17 +
 rtl/and_result_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// Types and constants shared by the 4-bit AND gate block and its result buffer.
package gates_pkg;

    localparam int GATE_W = 4;

    typedef struct packed {
        logic [0:GATE_W-1] y1;
        logic              y2;
    } result_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage

// File: rtl/ones_count.sv
// Combinational population count of a result vector.
module ones_count #(
    parameter int WIDTH = 4
) (
    input  logic [0:WIDTH-1]               vec,
    output logic [$clog2(WIDTH+1)-1:0]     ones
);
    localparam int OW = $clog2(WIDTH+1);

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + OW'(vec[i]);
        end
    end

endmodule

// File: rtl/and_result_buffer.sv
// Small FIFO that holds AND-gate results for a valid/ready consumer, with head
// popcount and a saturating count of accepted all-ones results.
module and_result_buffer
    import gates_pkg::*;
#(
    parameter int WIDTH = GATE_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [0:WIDTH-1]              y1,
    input  logic                          y2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [0:WIDTH-1]              out_y1,
    output logic                          out_y2,
    output logic [$clog2(WIDTH+1)-1:0]    out_ones,
    output logic [$clog2(DEPTH+1)-1:0]    level,
    output logic [CNT_W-1:0]              all_ones_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]    level_reg, level_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    occ_t             occ;
    logic             push, pop;
    logic [WIDTH:0]   wr_entry, head_entry;
    logic [0:WIDTH-1] head_y1;

    // Entries are packed {y1, y2} so y1[0] lands in the MSB, same as result_t.
    assign wr_entry = {y1, y2};

    generate
        if (WIDTH == GATE_W) begin : g_struct_mem
            result_t mem [DEPTH];
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_reg] <= result_t'(wr_entry);
            end
            assign head_entry = mem[rd_ptr_reg];
        end else begin : g_raw_mem
            logic [WIDTH:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr_reg] <= wr_entry;
            end
            assign head_entry = mem[rd_ptr_reg];
        end
    endgenerate

    always_comb begin
        occ = OCC_PARTIAL;
        if (level_reg == '0)              occ = OCC_EMPTY;
        else if (level_reg == LW'(DEPTH)) occ = OCC_FULL;
    end

    assign in_ready  = (occ != OCC_FULL) && !reset;
    assign out_valid = (occ != OCC_EMPTY) && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        cnt_next    = cnt_reg;
        if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
        if (push && y2 && (cnt_reg != {CNT_W{1'b1}})) cnt_next = cnt_reg + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign head_y1 = out_valid ? head_entry[WIDTH:1] : '0;
    assign out_y1  = head_y1;
    assign out_y2  = out_valid ? head_entry[0] : 1'b0;

    ones_count #(.WIDTH(WIDTH)) u_ones (
        .vec  (head_y1),
        .ones (out_ones)
    );

    assign level        = level_reg;
    assign all_ones_cnt = cnt_reg;

endmodule
